frame_checker: RTL and testbench

Receive-side counterpart of the speed tester's frame generator: consumes the AXI-Stream frames returned by the router under test and classifies each one by the stream ID carried in `axis_s_id`. Per-ID sequence numbers carried in each test frame are checked for loss or reordering, and frame, byte and error statistics are accumulated for readout by the control logic. It sits between the receive MAC-side AXIS path and the statistics/register block, one instance per tested port.

---
 rtl/frame_checker_pkg.sv | 30 +++
 rtl/keep_popcount.sv | 20 ++
 rtl/frame_checker.sv | 203 ++++++++++++++++++++
 tb/tb_frame_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_checker_pkg.sv
// Shared frame layout and FSM encodings for the speed-tester receive checker.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
// Contents: byte offsets of the sequence number and timestamp inside a test frame,
// the minimum length that carries a sequence number, and the checker state type.
package frame_checker_pkg;

  localparam int BEAT_BYTES    = 8;
  localparam int SEQ_OFFSET    = 42;
  localparam int TS_OFFSET     = 46;
  localparam int MIN_CHECK_LEN = 46;

  // Beat index and starting byte lane of each field for a 64-bit bus.
  localparam int SEQ_BEAT = SEQ_OFFSET / BEAT_BYTES;
  localparam int SEQ_LANE = SEQ_OFFSET % BEAT_BYTES;
  localparam int TS_BEAT  = TS_OFFSET / BEAT_BYTES;
  localparam int TS_LANE  = TS_OFFSET % BEAT_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Saturating increment for the 32-bit error counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/keep_popcount.sv
// Counts the set bits of an AXIS keep vector, giving the byte count of a beat.
// Latency: combinational.
// Backpressure: n/a.
// Ports: keep (byte enables) in, count (number of enabled bytes) out.
module keep_popcount #(
  parameter int KEEP_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(KEEP_WIDTH) + 1
) (
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [CNT_WIDTH-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      count = count + CNT_WIDTH'(keep[i]);
    end
  end

endmodule

// File: rtl/frame_checker.sv
// Receive-side test-frame checker: per-ID sequence tracking plus frame/byte/error statistics.
// Latency: statistics update one cycle after the last beat is accepted.
// Backpressure: none; axis_s_ready is tied high, full rate back-to-back frames.
// Ports: clk/rst, start/stop control pulses, running status, timestamp (latency only),
// AXIS slave (data/keep/last/user/id/valid/ready), statistics rx_frames/rx_bytes/err_*.
// Optional: FRAME_CHECKER_LATENCY_EN adds lat_sum/lat_max latency statistics.
module frame_checker
  import frame_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  output logic                    running,
  input  logic [31:0]             timestamp,
  input  logic [DATA_WIDTH-1:0]   axis_s_data,
  input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
  input  logic                    axis_s_last,
  input  logic [DATA_WIDTH/8-1:0] axis_s_user,
  input  logic [ID_WIDTH-1:0]     axis_s_id,
  input  logic                    axis_s_valid,
  output logic                    axis_s_ready,
  output logic [63:0]             rx_frames,
  output logic [63:0]             rx_bytes,
  output logic [31:0]             err_bad,
  output logic [31:0]             err_short,
  output logic [31:0]             err_seq
`ifdef FRAME_CHECKER_LATENCY_EN
  ,
  output logic [63:0]             lat_sum,
  output logic [31:0]             lat_max
`endif
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(KEEP_W) + 1;
  localparam int NUM_ID = 1 << ID_WIDTH;

  localparam logic [3:0]  BEAT_SEQ = 4'(SEQ_BEAT);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_CHECK_LEN);

  state_t state, state_nxt;

  logic [3:0]              beat_cnt;   // index of the next beat, saturates at 15
  logic [15:0]             byte_cnt;   // bytes accepted so far in this frame
  logic                    frame_act;  // current frame started in RUN
  logic [31:0]             seq_q;
  logic [NUM_ID-1:0]       trk_vld;
  logic [NUM_ID-1:0][31:0] exp_seq;

  logic [CNT_W-1:0] keep_cnt;
  logic             first_beat, active_now, mid_frame, commit;
  logic [15:0]      base_len, frame_len;
  logic [16:0]      len_sum;
  logic [31:0]      seq_beat, seq_now, exp_cur;
  logic             trk_hit, is_bad, is_short, seq_err;

  keep_popcount #(
    .KEEP_WIDTH(KEEP_W),
    .CNT_WIDTH (CNT_W)
  ) u_keep_popcount (
    .keep (axis_s_keep),
    .count(keep_cnt)
  );

  assign axis_s_ready = 1'b1;

  // Fields not needed in every build are folded into one sink.
  logic unused_bits;
  assign unused_bits = ^{axis_s_user[KEEP_W-1:1], axis_s_data, timestamp};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    running   = (state != ST_IDLE);
    // A frame is open if a beat was already taken or one is arriving now,
    // unless the arriving beat closes it.
    mid_frame = ((beat_cnt != 4'd0) || axis_s_valid) && !(axis_s_valid && axis_s_last);
    case (state)
      ST_RUN:   if (stop) state_nxt = mid_frame ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (axis_s_valid && axis_s_last) state_nxt = ST_IDLE;
      default:  state_nxt = state;
    endcase
    if (start) state_nxt = ST_RUN;
  end

  // ---------------------------------------------------------- datapath
  assign seq_beat = {axis_s_data[SEQ_LANE*8 +: 8],     axis_s_data[(SEQ_LANE+1)*8 +: 8],
                     axis_s_data[(SEQ_LANE+2)*8 +: 8], axis_s_data[(SEQ_LANE+3)*8 +: 8]};

  always_comb begin
    first_beat = (beat_cnt == 4'd0);
    active_now = first_beat ? (state == ST_RUN) : frame_act;
    base_len   = first_beat ? 16'd0 : byte_cnt;
    len_sum    = {1'b0, base_len} + 17'(keep_cnt);
    frame_len  = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    // The last beat may itself carry the sequence number.
    seq_now    = (beat_cnt == BEAT_SEQ) ? seq_beat : seq_q;
    trk_hit    = trk_vld[axis_s_id];
    exp_cur    = exp_seq[axis_s_id];
    is_bad     = axis_s_user[0];
    is_short   = !is_bad && (frame_len < MIN_LEN);
    seq_err    = !is_bad && !is_short && trk_hit && (seq_now != exp_cur);
    // A start on the closing beat discards the frame.
    commit     = axis_s_valid && axis_s_last && active_now && !start;
  end

`ifdef FRAME_CHECKER_LATENCY_EN
  localparam logic [3:0] BEAT_TS  = 4'(TS_BEAT);
  localparam logic [3:0] BEAT_TS2 = 4'(TS_BEAT + 1);

  logic [15:0] ts_hi_q, ts_lo_q, ts_hi_beat, ts_lo_beat;
  logic [31:0] ts_now, lat_now;

  // Frame timestamp straddles two beats: upper half in the last lanes of one
  // beat, lower half in the first lanes of the next.
  assign ts_hi_beat = {axis_s_data[TS_LANE*8 +: 8], axis_s_data[(TS_LANE+1)*8 +: 8]};
  assign ts_lo_beat = {axis_s_data[7:0], axis_s_data[15:8]};
  assign ts_now  = {(beat_cnt == BEAT_TS)  ? ts_hi_beat : ts_hi_q,
                    (beat_cnt == BEAT_TS2) ? ts_lo_beat : ts_lo_q};
  assign lat_now = timestamp - ts_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_hi_q <= '0;
      ts_lo_q <= '0;
    end else if (axis_s_valid) begin
      if (beat_cnt == BEAT_TS)  ts_hi_q <= ts_hi_beat;
      if (beat_cnt == BEAT_TS2) ts_lo_q <= ts_lo_beat;
    end
  end
`endif

  // Frame position tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      byte_cnt  <= '0;
      frame_act <= 1'b0;
      seq_q     <= '0;
    end else begin
      if (axis_s_valid) begin
        if (axis_s_last) begin
          beat_cnt <= '0;
          byte_cnt <= '0;
        end else begin
          if (beat_cnt != 4'hF) beat_cnt <= beat_cnt + 4'd1;
          byte_cnt <= frame_len;
        end
        if (first_beat)            frame_act <= (state == ST_RUN);
        if (beat_cnt == BEAT_SEQ)  seq_q     <= seq_beat;
      end
      // Whatever is in flight when start lands is never counted.
      if (start) frame_act <= 1'b0;
    end
  end

  // Statistics and per-ID sequence trackers.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      rx_frames <= '0;
      rx_bytes  <= '0;
      err_bad   <= '0;
      err_short <= '0;
      err_seq   <= '0;
      trk_vld   <= '0;
      exp_seq   <= '0;
`ifdef FRAME_CHECKER_LATENCY_EN
      lat_sum   <= '0;
      lat_max   <= '0;
`endif
    end else if (commit) begin
      rx_bytes <= rx_bytes + 64'(frame_len);
      if (is_bad) begin
        err_bad <= sat_inc32(err_bad);
      end else if (is_short) begin
        err_short <= sat_inc32(err_short);
      end else begin
        // Seed, advance or resync: all leave expected = seq + 1.
        trk_vld[axis_s_id] <= 1'b1;
        exp_seq[axis_s_id] <= seq_now + 32'd1;
        if (seq_err) begin
          err_seq <= sat_inc32(err_seq);
        end else begin
          rx_frames <= rx_frames + 64'd1;
`ifdef FRAME_CHECKER_LATENCY_EN
          lat_sum <= lat_sum + 64'(lat_now);
          if (lat_now > lat_max) lat_max <= lat_now;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_checker.sv
// Scoreboard bench for frame_checker: stimulus pushes expected statistics,
// a monitor pops and compares after every closing beat or explicit probe.
module tb_frame_checker;

  logic        clk = 1'b0;
  logic        rst, start, stop, running, probe;
  logic [31:0] timestamp;
  logic [63:0] axis_s_data;
  logic [7:0]  axis_s_keep, axis_s_user;
  logic        axis_s_last, axis_s_valid, axis_s_ready;
  logic [2:0]  axis_s_id;
  logic [63:0] rx_frames, rx_bytes;
  logic [31:0] err_bad, err_short, err_seq;
`ifdef FRAME_CHECKER_LATENCY_EN
  logic [63:0] lat_sum;
  logic [31:0] lat_max;
  localparam bit LAT = 1'b1;
`else
  localparam bit LAT = 1'b0;
`endif

  always #5 clk = ~clk;

  frame_checker #(.DATA_WIDTH(64), .ID_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .running(running),
    .timestamp(timestamp), .axis_s_data(axis_s_data), .axis_s_keep(axis_s_keep),
    .axis_s_last(axis_s_last), .axis_s_user(axis_s_user), .axis_s_id(axis_s_id),
    .axis_s_valid(axis_s_valid), .axis_s_ready(axis_s_ready),
    .rx_frames(rx_frames), .rx_bytes(rx_bytes), .err_bad(err_bad),
    .err_short(err_short), .err_seq(err_seq)
`ifdef FRAME_CHECKER_LATENCY_EN
    , .lat_sum(lat_sum), .lat_max(lat_max)
`endif
  );

  typedef struct {
    logic [63:0] frm;
    logic [63:0] byt;
    logic [31:0] bad;
    logic [31:0] sht;
    logic [31:0] sqe;
    logic        run;
    logic [63:0] lsum;
    logic [31:0] lmax;
    bit          chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_stats(input logic [63:0] f, input logic [63:0] b, input logic [31:0] bd,
                              input logic [31:0] sh, input logic [31:0] sq, input logic run,
                              input logic [63:0] ls = 64'd0, input logic [31:0] lm = 32'd0,
                              input bit cl = 1'b0);
    exp_t e;
    e.frm = f; e.byt = b; e.bad = bd; e.sht = sh; e.sqe = sq; e.run = run;
    e.lsum = ls; e.lmax = lm; e.chk_lat = cl;
    sb_q.push_back(e);
  endtask

  // Monitor: an output event is a closing beat or a probe; statistics are
  // sampled on the following falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if ((axis_s_valid && axis_s_ready && axis_s_last) || probe) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: output event with no expectation queued (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("rx_frames", rx_frames, e.frm);
          chk("rx_bytes", rx_bytes, e.byt);
          chk("err_bad", 64'(err_bad), 64'(e.bad));
          chk("err_short", 64'(err_short), 64'(e.sht));
          chk("err_seq", 64'(err_seq), 64'(e.sqe));
          chk("running", 64'(running), 64'(e.run));
          chk("axis_s_ready", 64'(axis_s_ready), 64'd1);
`ifdef FRAME_CHECKER_LATENCY_EN
          if (e.chk_lat) begin
            chk("lat_sum", lat_sum, e.lsum);
            chk("lat_max", 64'(lat_max), 64'(e.lmax));
          end
`endif
        end
      end
    end
  end

  task automatic defaults();
    start = 1'b0; stop = 1'b0; rst = 1'b0; probe = 1'b0;
    axis_s_valid = 1'b0; axis_s_last = 1'b0; axis_s_keep = 8'h00;
    axis_s_user = 8'h00; axis_s_data = 64'd0; axis_s_id = 3'd0;
  endtask

  // One idle cycle with optional control pulses.
  task automatic cyc(input bit s, input bit p, input bit r, input bit pr);
    @(negedge clk);
    defaults();
    start = s; stop = p; rst = r; probe = pr;
  endtask

  // ctl_kind: 0 none, 1 stop, 2 start, 3 rst, applied on beat ctl_beat.
  task automatic send_frame(input int id, input logic [31:0] seq, input logic [31:0] fts,
                            input int len, input bit bad, input int ctl_beat, input int ctl_kind,
                            input logic [31:0] rx_ts);
    logic [7:0] fb [128];
    int nb;
    for (int i = 0; i < 128; i++) fb[i] = 8'(i);
    fb[42] = seq[31:24]; fb[43] = seq[23:16]; fb[44] = seq[15:8]; fb[45] = seq[7:0];
    fb[46] = fts[31:24]; fb[47] = fts[23:16]; fb[48] = fts[15:8]; fb[49] = fts[7:0];
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      defaults();
      axis_s_valid = 1'b1;
      axis_s_id    = 3'(id);
      timestamp    = rx_ts;
      for (int l = 0; l < 8; l++) begin
        axis_s_data[l*8 +: 8] = fb[b*8 + l];
        axis_s_keep[l]        = (b*8 + l) < len;
      end
      axis_s_last = (b == nb - 1);
      axis_s_user = {7'd0, (b == nb - 1) && bad};
      if (b == ctl_beat) begin
        stop  = (ctl_kind == 1);
        start = (ctl_kind == 2);
        rst   = (ctl_kind == 3);
      end
    end
  endtask

  initial begin
    int wait_cyc;
    defaults();
    timestamp = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    expect_stats(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    // start -> RUN with everything clear.
    cyc(1, 0, 0, 0);
    expect_stats(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // ID 2, seq 7/8/9, 64 bytes each, back to back.
    expect_stats(1, 64, 0, 0, 0, 1);   send_frame(2, 7, 0, 64, 0, -1, 0, 0);
    expect_stats(2, 128, 0, 0, 0, 1);  send_frame(2, 8, 0, 64, 0, -1, 0, 0);
    expect_stats(3, 192, 0, 0, 0, 1);  send_frame(2, 9, 0, 64, 0, -1, 0, 0);
    cyc(0, 0, 0, 0);

    // ID 1, seq 0,1,3,4,5: gap at 3 is one error, then resync.
    expect_stats(4, 256, 0, 0, 0, 1);  send_frame(1, 0, 0, 64, 0, -1, 0, 0);
    expect_stats(5, 320, 0, 0, 0, 1);  send_frame(1, 1, 0, 64, 0, -1, 0, 0);
    expect_stats(5, 384, 0, 0, 1, 1);  send_frame(1, 3, 0, 64, 0, -1, 0, 0);
    expect_stats(6, 448, 0, 0, 1, 1);  send_frame(1, 4, 0, 64, 0, -1, 0, 0);
    expect_stats(7, 512, 0, 0, 1, 1);  send_frame(1, 5, 0, 64, 0, -1, 0, 0);

    // 40-byte short frame, then a 64-byte frame flagged bad.
    expect_stats(7, 552, 0, 1, 1, 1);  send_frame(3, 0, 0, 40, 0, -1, 0, 0);
    expect_stats(7, 616, 1, 1, 1, 1);  send_frame(3, 0, 0, 64, 1, -1, 0, 0);
    cyc(0, 0, 0, 0);

    // stop on beat 3: frame completes and counts, then IDLE ignores the next.
    expect_stats(8, 680, 1, 1, 1, 0);  send_frame(2, 10, 0, 64, 0, 3, 1, 0);
    expect_stats(8, 680, 1, 1, 1, 0);  send_frame(2, 11, 0, 64, 0, -1, 0, 0);
    cyc(0, 0, 0, 0);

    // start mid-frame: frame discarded, counters cleared, trackers cleared.
    expect_stats(0, 0, 0, 0, 0, 1);    send_frame(2, 12, 0, 64, 0, 3, 2, 0);
    expect_stats(1, 64, 0, 0, 0, 1);   send_frame(2, 50, 0, 64, 0, -1, 0, 0);
    cyc(0, 0, 0, 0);

    // start and stop together: start wins.
    expect_stats(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 1);
    expect_stats(1, 64, 0, 0, 0, 1);   send_frame(0, 0, 0, 64, 0, -1, 0, 0);
    // rst mid-frame: everything clears, rest of the frame is not counted.
    expect_stats(0, 0, 0, 0, 0, 0);    send_frame(0, 1, 0, 64, 0, 2, 3, 0);
    cyc(0, 0, 0, 0);

    // Length boundary: 45 bytes is short, 46 bytes is checked and counted.
    cyc(1, 0, 0, 0);
    expect_stats(0, 45, 0, 1, 0, 1);   send_frame(4, 9, 0, 45, 0, -1, 0, 0);
    expect_stats(1, 91, 0, 1, 0, 1);   send_frame(4, 9, 0, 46, 0, -1, 0, 0);
    cyc(0, 0, 0, 0);

    // Latency: sent at 100/200, received at 150/320.
    cyc(1, 0, 0, 0);
    expect_stats(1, 64, 0, 0, 0, 1, 50, 50, LAT);    send_frame(5, 0, 100, 64, 0, -1, 0, 150);
    expect_stats(2, 128, 0, 0, 0, 1, 170, 120, LAT); send_frame(5, 1, 200, 64, 0, -1, 0, 320);
    cyc(0, 0, 0, 0);

    wait_cyc = 0;
    while (sb_q.size() != 0 && wait_cyc < 20) begin
      cyc(0, 0, 0, 0);
      wait_cyc++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_left: %0d expectations never matched by an output event", sb_q.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
